// File: rtl/cpu_eu_pkg.sv
// Shared definitions for the execution-unit memory transfer sequencer.
// Provides the state encoding (as raw localparams and as a typed enum built
// from them) and the default wait-timeout length.
package cpu_eu_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] BEAT0 = 3'd2;
  localparam logic [2:0] INC   = 3'd3;
  localparam logic [2:0] BEAT1 = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 15;

  typedef enum logic [2:0] {
    StIdle  = IDLE,
    StAddr  = ADDR,
    StBeat0 = BEAT0,
    StInc   = INC,
    StBeat1 = BEAT1,
    StDone  = DONE
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state timer for one memory beat.
// Ports:
//   Clk, Reset : clock and asynchronous active-high reset
//   clr        : restart the count (asserted the cycle before a beat begins)
//   en         : the sequencer is in a beat state
//   rdy        : memory beat acknowledge
//   expired    : this cycle is the TIMEOUT_CYCLES-th consecutive wait cycle
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned TMR_W          = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  input  logic rdy,
  output logic expired
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // cnt_q counts wait cycles already seen, so the limit is hit on the
  // cycle where TIMEOUT_CYCLES-1 waits have elapsed and rdy is still low.
  assign expired = en && !rdy && (cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !rdy && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_xfer_seq.sv
// Data-memory transfer sequencer: turns one load/store request into one
// (single) or two (double, low word first) 32-bit bus beats, driving MAR,
// read/write buffer controls and the data-memory strobes.
// Optional feature macro: MEM_WAIT_TIMEOUT_EN (abort a beat after
// TIMEOUT_CYCLES wait cycles and flag err; otherwise waits forever).
// Ports:
//   Clk, Reset          : clock, asynchronous active-high reset
//   req, we, dbl        : request, store/load, 64/32-bit (latched in IDLE)
//   mem_rdy             : memory beat acknowledge
//   busy, done, err     : status; done is a one-cycle pulse, err valid with it
//   MAR_ld, MAR_inc     : MAR load / increment
//   RdBuf0_ld/RdBuf1_ld : capture low / high read word
//   WrBuf0_oe/WrBuf1_oe : drive low / high write word
//   dM_cs, dM_rd, dM_wr : data-memory strobes
module mem_xfer_seq
  import cpu_eu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TMR_W          = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic req,
  input  logic we,
  input  logic dbl,
  input  logic mem_rdy,
  output logic busy,
  output logic done,
  output logic err,
  output logic MAR_ld,
  output logic MAR_inc,
  output logic RdBuf0_ld,
  output logic RdBuf1_ld,
  output logic WrBuf0_oe,
  output logic WrBuf1_oe,
  output logic dM_cs,
  output logic dM_rd,
  output logic dM_wr
);

  if (2 ** TMR_W <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("TMR_W is too narrow to count to TIMEOUT_CYCLES");
  end

  state_e state_q, state_d;
  logic   we_q, we_d;
  logic   dbl_q, dbl_d;
  logic   tmr_expired;

`ifdef MEM_WAIT_TIMEOUT_EN
  logic err_q, err_d;
  logic tmr_clr, tmr_en;

  // Clear the timer the cycle before each beat so every beat starts at zero.
  assign tmr_clr = (state_q == StAddr) || (state_q == StInc);
  assign tmr_en  = (state_q == StBeat0) || (state_q == StBeat1);
  assign err     = err_q;

  mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TMR_W          (TMR_W)
  ) u_mem_wait_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .rdy     (mem_rdy),
    .expired (tmr_expired)
  );

  always_comb begin
    err_d = err_q;
    if (state_q == StIdle && req) begin
      err_d = 1'b0;
    end else if (tmr_expired) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign tmr_expired = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    dbl_d     = dbl_q;
    busy      = 1'b1;
    done      = 1'b0;
    MAR_ld    = 1'b0;
    MAR_inc   = 1'b0;
    RdBuf0_ld = 1'b0;
    RdBuf1_ld = 1'b0;
    WrBuf0_oe = 1'b0;
    WrBuf1_oe = 1'b0;
    dM_cs     = 1'b0;
    dM_rd     = 1'b0;
    dM_wr     = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (req) begin
          we_d    = we;
          dbl_d   = dbl;
          state_d = StAddr;
        end
      end
      StAddr: begin
        MAR_ld  = 1'b1;
        state_d = StBeat0;
      end
      StBeat0: begin
        dM_cs     = 1'b1;
        dM_rd     = !we_q;
        dM_wr     = we_q;
        WrBuf0_oe = we_q;
        if (mem_rdy) begin
          RdBuf0_ld = !we_q;
          state_d   = dbl_q ? StInc : StDone;
        end else if (tmr_expired) begin
          // Abort skips any remaining beat.
          state_d = StDone;
        end
      end
      StInc: begin
        MAR_inc = 1'b1;
        state_d = StBeat1;
      end
      StBeat1: begin
        dM_cs     = 1'b1;
        dM_rd     = !we_q;
        dM_wr     = we_q;
        WrBuf1_oe = we_q;
        if (mem_rdy) begin
          RdBuf1_ld = !we_q;
          state_d   = StDone;
        end else if (tmr_expired) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      dbl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      dbl_q   <= dbl_d;
    end
  end

endmodule
